// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter between two ALU requesters. It muxes the
// winning operation onto the shared combinational ALU and captures the result
// in a one-entry response buffer tagged with the winner's id.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_rs,
  input  logic [W-1:0] req0_rt,
  input  logic [W-1:0] req0_imm,
  input  logic         req0_useimm,
  input  logic [7:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_rs,
  input  logic [W-1:0] req1_rt,
  input  logic [W-1:0] req1_imm,
  input  logic         req1_useimm,
  input  logic [7:0]   req1_sel,
  output logic [W-1:0] alu_rs,
  output logic [W-1:0] alu_rt,
  output logic [W-1:0] alu_imm,
  output logic         alu_useimm,
  output logic [7:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_id,
  output logic [15:0]  op_count
);

  logic         resp_valid_q;
  logic [W-1:0] resp_data_q;
  logic         resp_id_q;
  logic         last_id_q;
  logic [15:0]  op_count_q;

  logic         can_accept;
  logic         grant;
  logic         win;

  // Buffer can take a new result when empty or draining this same cycle.
  // Reset gates the grant so readies and ALU operands read 0 while held.
  assign can_accept = !resp_valid_q || resp_ready;
  assign grant      = reset_n && can_accept && (req0_valid || req1_valid);
  assign req0_ready = grant && !win;
  assign req1_ready = grant && win;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      win = ~last_id_q;
    end else if (req1_valid) begin
      win = 1'b1;
    end
  end

  // ALU operand mux: winner's operation while granted, all zero otherwise.
  always_comb begin
    alu_rs     = '0;
    alu_rt     = '0;
    alu_imm    = '0;
    alu_useimm = 1'b0;
    alu_sel    = 8'd0;
    if (grant) begin
      if (win) begin
        alu_rs     = req1_rs;
        alu_rt     = req1_rt;
        alu_imm    = req1_imm;
        alu_useimm = req1_useimm;
        alu_sel    = req1_sel;
      end else begin
        alu_rs     = req0_rs;
        alu_rt     = req0_rt;
        alu_imm    = req0_imm;
        alu_useimm = req0_useimm;
        alu_sel    = req0_sel;
      end
    end
  end

  // Response buffer, round-robin history and accept counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      last_id_q    <= 1'b1;
      op_count_q   <= 16'd0;
    end else if (grant) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= alu_out;
      resp_id_q    <= win;
      last_id_q    <= win;
      op_count_q   <= op_count_q + 16'd1;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small behavioural ALU.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [7:0] SEL_ADD = 8'h21;
  localparam logic [7:0] SEL_SUB = 8'h23;
  localparam logic [7:0] SEL_OR  = 8'h25;
  localparam logic [W-1:0] UNDEF_RESULT = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0_valid, req0_ready, req0_useimm;
  logic [W-1:0] req0_rs, req0_rt, req0_imm;
  logic [7:0]   req0_sel;
  logic         req1_valid, req1_ready, req1_useimm;
  logic [W-1:0] req1_rs, req1_rt, req1_imm;
  logic [7:0]   req1_sel;
  logic [W-1:0] alu_rs, alu_rt, alu_imm, alu_out;
  logic         alu_useimm;
  logic [7:0]   alu_sel;
  logic         resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_data;
  logic [15:0]  op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_imm(req0_imm),
    .req0_useimm(req0_useimm), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_imm(req1_imm),
    .req1_useimm(req1_useimm), .req1_sel(req1_sel),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_imm(alu_imm),
    .alu_useimm(alu_useimm), .alu_sel(alu_sel), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .op_count(op_count)
  );

  // Behavioural ALU driven by the arbiter's operand outputs.
  always_comb begin
    logic [W-1:0] b;
    b = alu_useimm ? alu_imm : alu_rt;
    case (alu_sel)
      SEL_ADD: alu_out = alu_rs + b;
      SEL_SUB: alu_out = alu_rs - b;
      SEL_OR:  alu_out = alu_rs | b;
      default: alu_out = UNDEF_RESULT;
    endcase
  end

  task automatic clear_reqs();
    req0_valid = 0; req0_rs = 0; req0_rt = 0; req0_imm = 0; req0_useimm = 0; req0_sel = 0;
    req1_valid = 0; req1_rs = 0; req1_rt = 0; req1_imm = 0; req1_useimm = 0; req1_sel = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    // Load some state, then assert reset mid-cycle with a request pending.
    clear_reqs();
    resp_ready = 1;
    req0_valid = 1; req0_sel = SEL_ADD; req0_rs = 3; req0_rt = 4;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || op_count !== 16'd1) begin
      errors++; $display("FAIL reset_preload: valid=%b count=%0d, required 1/1", resp_valid, op_count);
    end
    @(negedge clk); #2 reset_n = 0;
    #1;
    checks++;
    if (resp_valid !== 0 || resp_data !== 0 || resp_id !== 0 || op_count !== 0) begin
      errors++; $display("FAIL reset_resp: valid=%b data=%h id=%b count=%0d, required all 0",
                         resp_valid, resp_data, resp_id, op_count);
    end
    checks++;
    if (req0_ready !== 0 || req1_ready !== 0 || alu_rs !== 0 || alu_rt !== 0 ||
        alu_imm !== 0 || alu_useimm !== 0 || alu_sel !== 0) begin
      errors++; $display("FAIL reset_ready_alu: r0=%b r1=%b rs=%h rt=%h imm=%h ui=%b sel=%h, required all 0",
                         req0_ready, req1_ready, alu_rs, alu_rt, alu_imm, alu_useimm, alu_sel);
    end
    clear_reqs();
    @(posedge clk); #1 reset_n = 1;
  endtask

  task automatic test_single_add();
    apply_reset();
    resp_ready = 1;
    req0_valid = 1; req0_sel = SEL_ADD; req0_rs = 5; req0_rt = 7; req0_useimm = 0;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1 || req1_ready !== 0 || alu_rs !== 5 || alu_rt !== 7 || alu_sel !== SEL_ADD) begin
      errors++; $display("FAIL add_grant: r0=%b r1=%b rs=%0d rt=%0d sel=%h, required 1 0 5 7 %h",
                         req0_ready, req1_ready, alu_rs, alu_rt, alu_sel, SEL_ADD);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    checks++;
    if (resp_valid !== 1 || resp_data !== 12 || resp_id !== 0 || op_count !== 1) begin
      errors++; $display("FAIL add_resp: valid=%b data=%0d id=%b count=%0d, required 1 12 0 1",
                         resp_valid, resp_data, resp_id, op_count);
    end
    @(negedge clk);
    checks++;
    if (req0_ready !== 0 || alu_sel !== 0 || alu_rs !== 0) begin
      errors++; $display("FAIL idle_alu: r0=%b sel=%h rs=%h, required 0 0 0", req0_ready, alu_sel, alu_rs);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 0 || resp_data !== 12 || resp_id !== 0 || op_count !== 1) begin
      errors++; $display("FAIL drain: valid=%b data=%0d id=%b count=%0d, required 0 12 0 1",
                         resp_valid, resp_data, resp_id, op_count);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_data;
    logic         exp_id;
    apply_reset();
    resp_ready = 1;
    req0_valid = 1; req0_sel = SEL_SUB; req0_rs = 10; req0_imm = 3; req0_useimm = 1; req0_rt = 99;
    req1_valid = 1; req1_sel = SEL_OR;  req1_rs = 32'hF0; req1_rt = 32'h0F; req1_useimm = 0; req1_imm = 55;
    for (int k = 0; k < 4; k++) begin
      exp_id   = (k % 2 == 1);
      exp_data = exp_id ? 32'hFF : 32'd7;
      @(negedge clk);
      checks++;
      if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        errors++; $display("FAIL rr_grant[%0d]: r0=%b r1=%b, required r%0d only", k, req0_ready, req1_ready, exp_id);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1 || resp_id !== exp_id || resp_data !== exp_data || op_count !== 16'(k + 1)) begin
        errors++; $display("FAIL rr_resp[%0d]: valid=%b id=%b data=%h count=%0d, required 1 %b %h %0d",
                           k, resp_valid, resp_id, resp_data, op_count, exp_id, exp_data, k + 1);
      end
    end
    clear_reqs();
  endtask

  task automatic test_back_pressure();
    apply_reset();
    resp_ready = 1;
    req0_valid = 1; req0_sel = SEL_ADD; req0_rs = 1; req0_rt = 2;
    @(posedge clk); #1;
    clear_reqs();
    resp_ready = 0;
    req1_valid = 1; req1_sel = SEL_SUB; req1_rs = 9; req1_imm = 4; req1_useimm = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req0_ready !== 0 || req1_ready !== 0 || alu_sel !== 0) begin
        errors++; $display("FAIL stall_ready[%0d]: r0=%b r1=%b sel=%h, required 0 0 0",
                           k, req0_ready, req1_ready, alu_sel);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1 || resp_data !== 3 || resp_id !== 0 || op_count !== 1) begin
        errors++; $display("FAIL stall_hold[%0d]: valid=%b data=%0d id=%b count=%0d, required 1 3 0 1",
                           k, resp_valid, resp_data, resp_id, op_count);
      end
    end
    resp_ready = 1;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1 || req0_ready !== 0) begin
      errors++; $display("FAIL bp_release_grant: r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    clear_reqs();
    checks++;
    if (resp_valid !== 1 || resp_data !== 5 || resp_id !== 1 || op_count !== 2) begin
      errors++; $display("FAIL bp_second: valid=%b data=%0d id=%b count=%0d, required 1 5 1 2",
                         resp_valid, resp_data, resp_id, op_count);
    end
  endtask

  task automatic test_undefined_sel();
    apply_reset();
    resp_ready = 1;
    req1_valid = 1; req1_sel = 8'hEE; req1_rs = 1; req1_rt = 2;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1 || alu_sel !== 8'hEE) begin
      errors++; $display("FAIL undef_pass: r1=%b sel=%h, required 1 ee", req1_ready, alu_sel);
    end
    @(posedge clk); #1;
    clear_reqs();
    checks++;
    if (resp_valid !== 1 || resp_data !== UNDEF_RESULT || resp_id !== 1) begin
      errors++; $display("FAIL undef_resp: valid=%b data=%h id=%b, required 1 %h 1",
                         resp_valid, resp_data, resp_id, UNDEF_RESULT);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    resp_ready = 0;
    req0_valid = 1; req0_sel = SEL_ADD; req0_rs = 2; req0_rt = 2;
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1 || resp_data !== 4) begin
      errors++; $display("FAIL pending: valid=%b data=%0d, required 1 4", resp_valid, resp_data);
    end
    @(negedge clk); reset_n = 0;
    #1;
    checks++;
    if (resp_valid !== 0 || resp_data !== 0 || op_count !== 0) begin
      errors++; $display("FAIL stall_reset: valid=%b data=%0d count=%0d, required 0 0 0",
                         resp_valid, resp_data, op_count);
    end
    @(posedge clk); #1 reset_n = 1;
    resp_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 0) begin
      errors++; $display("FAIL discarded: valid=%b, required 0", resp_valid);
    end
    req0_valid = 1; req0_sel = SEL_ADD; req0_rs = 20; req0_rt = 1;
    req1_valid = 1; req1_sel = SEL_OR;  req1_rs = 8;  req1_rt = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1 || req1_ready !== 0) begin
      errors++; $display("FAIL tie_after_reset: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    clear_reqs();
    checks++;
    if (resp_valid !== 1 || resp_id !== 0 || resp_data !== 21 || op_count !== 1) begin
      errors++; $display("FAIL tie_resp: valid=%b id=%b data=%0d count=%0d, required 1 0 21 1",
                         resp_valid, resp_id, resp_data, op_count);
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    resp_ready = 1;
    req0_valid = 1; req0_sel = SEL_ADD; req0_rs = 32'hFFFF_FFFF; req0_rt = 1;
    repeat (65535) @(posedge clk);
    #1;
    checks++;
    if (op_count !== 16'hFFFF || resp_data !== 0 || resp_valid !== 1) begin
      errors++; $display("FAIL count_ffff: count=%h data=%h valid=%b, required ffff 0 1",
                         op_count, resp_data, resp_valid);
    end
    @(posedge clk); #1;
    clear_reqs();
    checks++;
    if (op_count !== 16'h0000 || resp_data !== 0 || resp_valid !== 1) begin
      errors++; $display("FAIL count_wrap: count=%h data=%h valid=%b, required 0 0 1",
                         op_count, resp_data, resp_valid);
    end
  endtask

  initial begin
    clear_reqs();
    resp_ready = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    test_reset();
    test_single_add();
    test_round_robin();
    test_back_pressure();
    test_undefined_sel();
    test_reset_mid_stall();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
